// File: rtl/vdp_cpu_port_if.sv
// ---------------------------------------------------------------------------
// vdp_cpu_port_if
// Request/acknowledge bus between the CPU port and the VDP core.
//   vdp_req  : request valid, held until vdp_ack
//   vdp_wrt  : 1 = register write, 0 = register read
//   vdp_adr  : register select
//   vdp_dbo  : write data towards the core
//   vdp_ack  : core acknowledge (one cycle)
//   vdp_dbi  : read data from the core, valid with vdp_ack
// Modports: master (CPU port side), slave (VDP core side).
// ---------------------------------------------------------------------------
interface vdp_cpu_port_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              vdp_req;
    logic              vdp_wrt;
    logic [ADDR_W-1:0] vdp_adr;
    logic [DATA_W-1:0] vdp_dbo;
    logic              vdp_ack;
    logic [DATA_W-1:0] vdp_dbi;

    modport master (
        output vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
        input  vdp_ack, vdp_dbi
    );

    modport slave (
        input  vdp_req, vdp_wrt, vdp_adr, vdp_dbo,
        output vdp_ack, vdp_dbi
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// ---------------------------------------------------------------------------
// vdp_cpu_port
// Bridges an asynchronous CPU bus (write/read strobes) onto the VDP core
// request bus. Raw strobes and data are synchronised and the strobes are
// deglitched; writes are posted through a small FIFO, reads are issued only
// once all earlier writes have drained.
//
// Ports
//   clk_w, reset_n_w   : VDP clock, asynchronous active-low reset
//   csw_n, csr_n       : raw CPU write/read strobes (active low)
//   mode, cd_in        : raw CPU register select / write data
//   cd_out, cd_oe      : last read data, data-bus drive enable (= ~csr_n)
//   vdp                : request bus to the VDP core (master modport)
//   fifo_level         : posted-write FIFO occupancy
//   overflow           : sticky, set when a write is dropped on a full FIFO
//   wr_count, rd_count, drop_count : statistics counters
//
// Optional feature: define VDP_CPU_PORT_STATS_EN to enable the saturating
// statistics counters; otherwise they read as constant zero.
// ---------------------------------------------------------------------------
module vdp_cpu_port #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int FILT_LEN   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_w,
    input  logic                            reset_n_w,
    input  logic                            csw_n,
    input  logic                            csr_n,
    input  logic [ADDR_W-1:0]               mode,
    input  logic [DATA_W-1:0]               cd_in,
    output logic [DATA_W-1:0]               cd_out,
    output logic                            cd_oe,
    vdp_cpu_port_if.master                  vdp,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow,
    output logic [15:0]                     wr_count,
    output logic [15:0]                     rd_count,
    output logic [15:0]                     drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_HOLD
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers (reset to 1 so nothing looks like a strobe)
    // -----------------------------------------------------------------------
    logic [1:0]        r_csw_sync;
    logic [1:0]        r_csr_sync;
    logic [ADDR_W-1:0] r_mode_s1, r_mode_s2;
    logic [DATA_W-1:0] r_cd_s1, r_cd_s2;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_csw_sync <= '1;
            r_csr_sync <= '1;
            r_mode_s1  <= '1;
            r_mode_s2  <= '1;
            r_cd_s1    <= '1;
            r_cd_s2    <= '1;
        end else begin
            r_csw_sync <= {r_csw_sync[0], csw_n};
            r_csr_sync <= {r_csr_sync[0], csr_n};
            r_mode_s1  <= mode;
            r_mode_s2  <= r_mode_s1;
            r_cd_s1    <= cd_in;
            r_cd_s2    <= r_cd_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Strobe filters: index 0 = write strobe, index 1 = read strobe.
    // The counter tracks consecutive cycles where the synchronised value
    // differs from the filtered level; the level flips on the FILT_LEN-th.
    // -----------------------------------------------------------------------
    logic [1:0]       w_sync;
    logic [1:0]       w_flip;
    logic [1:0]       r_filt_lvl;
    logic [CNT_W-1:0] r_filt_cnt [2];

    assign w_sync = {r_csr_sync[1], r_csw_sync[1]};

    always_comb begin
        w_flip = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_flip[i] = (w_sync[i] != r_filt_lvl[i]) &&
                        (r_filt_cnt[i] == CNT_W'(FILT_LEN - 1));
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_filt_lvl <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                r_filt_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_sync[i] == r_filt_lvl[i]) begin
                    r_filt_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_filt_lvl[i] <= w_sync[i];
                    r_filt_cnt[i] <= '0;
                end else begin
                    r_filt_cnt[i] <= r_filt_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Falling edges are taken on the cycle the filtered level flips low.
    logic w_csw_fall, w_csr_fall, w_wr_stb, w_rd_stb;

    assign w_csw_fall = r_filt_lvl[0] & w_flip[0];
    assign w_csr_fall = r_filt_lvl[1] & w_flip[1];
    assign w_wr_stb   = w_csw_fall & r_filt_lvl[1] & ~w_csr_fall;
    assign w_rd_stb   = w_csr_fall & r_filt_lvl[0] & ~w_csw_fall;

    // -----------------------------------------------------------------------
    // Posted-write FIFO
    // The head entry is copied onto the bus when a write starts but is only
    // retired on vdp_ack, so an in-flight write still occupies its slot.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] r_fifo_adr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_dat [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;
    logic              w_full, w_empty, w_push, w_drop, w_retire;

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = w_wr_stb & (~w_full | w_retire);
    assign w_drop  = w_wr_stb & ~w_push;

    always_ff @(posedge clk_w) begin
        if (w_push) begin
            r_fifo_adr[r_wptr] <= r_mode_s2;
            r_fifo_dat[r_wptr] <= r_cd_s2;
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_retire) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_retire) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_retire) begin
                r_level <= r_level - LVL_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request FSM
    // -----------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic              w_load_wr, w_load_rd, w_rd_done;
    logic              r_rd_pending;
    logic [ADDR_W-1:0] r_rd_adr;
    logic              r_vdp_req, r_vdp_wrt;
    logic [ADDR_W-1:0] r_vdp_adr;
    logic [DATA_W-1:0] r_vdp_dbo;
    logic [DATA_W-1:0] r_cd_out;

    always_comb begin
        w_state_nxt = r_state;
        w_load_wr   = 1'b0;
        w_load_rd   = 1'b0;
        w_retire    = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = WR_REQ;
                    w_load_wr   = 1'b1;
                end else if (r_rd_pending) begin
                    w_state_nxt = RD_REQ;
                    w_load_rd   = 1'b1;
                end
            end
            WR_REQ: begin
                if (vdp.vdp_ack) begin
                    w_state_nxt = IDLE;
                    w_retire    = 1'b1;
                end
            end
            RD_REQ: begin
                if (vdp.vdp_ack) begin
                    w_state_nxt = RD_HOLD;
                    w_rd_done   = 1'b1;
                end
            end
            RD_HOLD: begin
                if (r_filt_lvl[1]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_state      <= IDLE;
            r_rd_pending <= 1'b0;
            r_rd_adr     <= '0;
            r_vdp_req    <= 1'b0;
            r_vdp_wrt    <= 1'b0;
            r_vdp_adr    <= '0;
            r_vdp_dbo    <= '0;
            r_cd_out     <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_rd_stb) begin
                r_rd_pending <= 1'b1;
                r_rd_adr     <= r_mode_s2;
            end else if (w_rd_done) begin
                r_rd_pending <= 1'b0;
            end

            if (w_load_wr) begin
                r_vdp_req <= 1'b1;
                r_vdp_wrt <= 1'b1;
                r_vdp_adr <= r_fifo_adr[r_rptr];
                r_vdp_dbo <= r_fifo_dat[r_rptr];
            end else if (w_load_rd) begin
                r_vdp_req <= 1'b1;
                r_vdp_wrt <= 1'b0;
                r_vdp_adr <= r_rd_adr;
            end else if (w_retire || w_rd_done) begin
                r_vdp_req <= 1'b0;
                r_vdp_wrt <= 1'b0;
            end

            if (w_rd_done) begin
                r_cd_out <= vdp.vdp_dbi;
            end
        end
    end

    assign vdp.vdp_req = r_vdp_req;
    assign vdp.vdp_wrt = r_vdp_wrt;
    assign vdp.vdp_adr = r_vdp_adr;
    assign vdp.vdp_dbo = r_vdp_dbo;
    assign cd_out      = r_cd_out;
    assign cd_oe       = ~csr_n;
    assign fifo_level  = r_level;
    assign overflow    = r_overflow;

    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
`ifdef VDP_CPU_PORT_STATS_EN
    logic [15:0] r_wr_cnt, r_rd_cnt, r_drop_cnt;

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_rd_done && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign wr_count   = r_wr_cnt;
    assign rd_count   = r_rd_cnt;
    assign drop_count = r_drop_cnt;
`else
    assign wr_count   = '0;
    assign rd_count   = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// ---------------------------------------------------------------------------
// tb_vdp_cpu_port
// Self-checking bench for vdp_cpu_port. A behavioural VDP core answers
// requests from its own register file; directed vectors, multi-cycle
// sequences and a randomized phase are checked against expectations that
// the bench derives from CPU-order register semantics.
// ---------------------------------------------------------------------------
module tb_vdp_cpu_port;

`ifdef VDP_CPU_PORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        csw_n = 1'b1;
    logic        csr_n = 1'b1;
    logic [1:0]  mode  = 2'd0;
    logic [7:0]  cd_in = 8'd0;
    logic [7:0]  cd_out;
    logic        cd_oe;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] wr_count, rd_count, drop_count;

    vdp_cpu_port_if #(.ADDR_W(2), .DATA_W(8)) vif ();

    vdp_cpu_port #(
        .ADDR_W(2), .DATA_W(8), .FILT_LEN(3), .FIFO_DEPTH(4)
    ) dut (
        .clk_w(clk), .reset_n_w(rst_n),
        .csw_n(csw_n), .csr_n(csr_n), .mode(mode), .cd_in(cd_in),
        .cd_out(cd_out), .cd_oe(cd_oe), .vdp(vif),
        .fifo_level(fifo_level), .overflow(overflow),
        .wr_count(wr_count), .rd_count(rd_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ----------------------------------------------------------------------
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] data;
    } txn_t;

    txn_t        obs[$];
    txn_t        exp_q[$];
    logic [7:0]  core_rf [4];
    logic [7:0]  exp_rf  [4];
    bit          ack_en  = 1'b1;
    int unsigned lat_cfg = 2;
    int unsigned n_req_rise = 0;

    // ----------------------------------------------------------------------
    // Behavioural VDP core: acks after a latency, serves its register file
    // ----------------------------------------------------------------------
    initial begin : core
        int unsigned cnt;
        int unsigned cur_lat;
        logic        prev_req;
        txn_t        t;
        cnt = 0; cur_lat = 1; prev_req = 1'b0;
        vif.vdp_ack = 1'b0;
        vif.vdp_dbi = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vif.vdp_ack = 1'b0;
                cnt = 0;
            end
            if (vif.vdp_req === 1'b1 && !prev_req) n_req_rise++;
            prev_req = (vif.vdp_req === 1'b1);
            if (vif.vdp_ack) begin
                vif.vdp_ack = 1'b0;
                cnt = 0;
            end else if (rst_n && vif.vdp_req === 1'b1 && ack_en) begin
                if (cnt == 0) cur_lat = (lat_cfg == 0) ? $urandom_range(1, 4) : lat_cfg;
                cnt++;
                if (cnt >= cur_lat) begin
                    t.wrt = vif.vdp_wrt;
                    t.adr = vif.vdp_adr;
                    if (vif.vdp_wrt) begin
                        core_rf[vif.vdp_adr] = vif.vdp_dbo;
                        t.data = vif.vdp_dbo;
                    end else begin
                        vif.vdp_dbi = core_rf[vif.vdp_adr];
                        t.data = core_rf[vif.vdp_adr];
                    end
                    obs.push_back(t);
                    vif.vdp_ack = 1'b1;
                end
            end
        end
    end

    // ----------------------------------------------------------------------
    // CPU-side tasks
    // ----------------------------------------------------------------------
    task automatic do_reset();
        rst_n = 1'b0; csw_n = 1'b1; csr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic cpu_write(input logic [1:0] m, input logic [7:0] d,
                             input int unsigned low_c, input int unsigned high_c);
        @(posedge clk); #1;
        mode = m; cd_in = d;
        @(posedge clk); #1;
        csw_n = 1'b0;
        repeat (low_c) @(posedge clk);
        #1 csw_n = 1'b1;
        repeat (high_c) @(posedge clk);
    endtask

    task automatic cpu_read(input logic [1:0] m, input int unsigned low_c,
                            input int unsigned high_c);
        @(posedge clk); #1;
        mode = m;
        chk("cd_oe_idle", cd_oe, 1'b0);
        @(posedge clk); #1;
        csr_n = 1'b0;
        #1 chk("cd_oe_drive", cd_oe, 1'b1);
        repeat (low_c) @(posedge clk);
        #1 csr_n = 1'b1;
        repeat (high_c) @(posedge clk);
    endtask

    task automatic cpu_both(input logic [1:0] m, input int unsigned low_c);
        @(posedge clk); #1;
        mode = m;
        @(posedge clk); #1;
        csw_n = 1'b0; csr_n = 1'b0;
        repeat (low_c) @(posedge clk);
        #1 begin csw_n = 1'b1; csr_n = 1'b1; end
        repeat (4) @(posedge clk);
    endtask

    // Bounded wait for a quiet bus with an empty FIFO.
    task automatic wait_idle(input string tag);
        int unsigned quiet = 0;
        int unsigned n = 0;
        while (quiet < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (vif.vdp_req === 1'b0 && fifo_level == 3'd0) quiet++;
            else quiet = 0;
        end
        chk({"idle_reached_", tag}, (quiet >= 8) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic compare_obs(input string tag);
        int unsigned n;
        txn_t e, o;
        chk({"txn_count_", tag}, obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = obs.pop_front();
            chk({"txn_wrt_", tag}, o.wrt, e.wrt);
            chk({"txn_adr_", tag}, o.adr, e.adr);
            chk({"txn_data_", tag}, o.data, e.data);
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic init_rf();
        core_rf[0] = 8'h3C; core_rf[1] = 8'h7E; core_rf[2] = 8'h00; core_rf[3] = 8'h00;
    endtask

    // ----------------------------------------------------------------------
    // Directed single-operation vectors
    // ----------------------------------------------------------------------
    localparam int K_WR = 0, K_RD = 1, K_GW = 2, K_GR = 3, K_BOTH = 4;

    typedef struct {
        int          kind;
        logic [1:0]  mode;
        logic [7:0]  data;
        int unsigned exp_n;
        logic        exp_wrt;
        logic [7:0]  exp_txd;
        logic [7:0]  exp_cd;
        int unsigned wr_d;
        int unsigned rd_d;
    } vec_t;

    vec_t vec [10];

    initial begin : main
        logic [15:0] wr0, rd0, dr0;
        int unsigned k;
        int unsigned op;
        logic [1:0]  m;
        logic [7:0]  d;
        txn_t        e;
        int unsigned exp_wr, exp_rd;
        logic [7:0]  exp_cd;

        vec[0] = '{K_WR,   2'd1, 8'hA5, 1, 1'b1, 8'hA5, 8'h00, 1, 0};
        vec[1] = '{K_GW,   2'd2, 8'h33, 0, 1'b0, 8'h00, 8'h00, 0, 0};
        vec[2] = '{K_RD,   2'd1, 8'h00, 1, 1'b0, 8'hA5, 8'hA5, 0, 1};
        vec[3] = '{K_WR,   2'd3, 8'hC3, 1, 1'b1, 8'hC3, 8'hA5, 1, 0};
        vec[4] = '{K_RD,   2'd3, 8'h00, 1, 1'b0, 8'hC3, 8'hC3, 0, 1};
        vec[5] = '{K_BOTH, 2'd0, 8'h00, 0, 1'b0, 8'h00, 8'hC3, 0, 0};
        vec[6] = '{K_RD,   2'd0, 8'h00, 1, 1'b0, 8'h3C, 8'h3C, 0, 1};
        vec[7] = '{K_GR,   2'd2, 8'h00, 0, 1'b0, 8'h00, 8'h3C, 0, 0};
        vec[8] = '{K_WR,   2'd2, 8'h5A, 1, 1'b1, 8'h5A, 8'h3C, 1, 0};
        vec[9] = '{K_RD,   2'd2, 8'h00, 1, 1'b0, 8'h5A, 8'h5A, 0, 1};

        init_rf();

        // Reset state, sampled while reset is held
        #12;
        chk("rst_vdp_req", vif.vdp_req, 1'b0);
        chk("rst_vdp_wrt", vif.vdp_wrt, 1'b0);
        chk("rst_vdp_adr", vif.vdp_adr, 2'd0);
        chk("rst_vdp_dbo", vif.vdp_dbo, 8'h00);
        chk("rst_cd_out", cd_out, 8'h00);
        chk("rst_fifo_level", fifo_level, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_wr_count", wr_count, 16'd0);
        chk("rst_rd_count", rd_count, 16'd0);
        chk("rst_drop_count", drop_count, 16'd0);
        chk("rst_cd_oe", cd_oe, 1'b0);
        do_reset();
        wait_idle("after_reset");
        chk("no_req_after_reset", n_req_rise, 0);

        // Table-driven single operations, core ack latency 2
        lat_cfg = 2;
        for (int i = 0; i < 10; i++) begin
            obs.delete();
            n_req_rise = 0;
            wr0 = wr_count; rd0 = rd_count; dr0 = drop_count;
            case (vec[i].kind)
                K_WR:    cpu_write(vec[i].mode, vec[i].data, 6, 3);
                K_GW:    cpu_write(vec[i].mode, vec[i].data, 2, 3);
                K_RD:    cpu_read(vec[i].mode, 10, 3);
                K_GR:    cpu_read(vec[i].mode, 2, 3);
                default: cpu_both(vec[i].mode, 6);
            endcase
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_ntxn", i), obs.size(), vec[i].exp_n);
            chk($sformatf("v%0d_req_pulses", i), n_req_rise, vec[i].exp_n);
            if (vec[i].exp_n == 1 && obs.size() >= 1) begin
                chk($sformatf("v%0d_wrt", i), obs[0].wrt, vec[i].exp_wrt);
                chk($sformatf("v%0d_adr", i), obs[0].adr, vec[i].mode);
                chk($sformatf("v%0d_data", i), obs[0].data, vec[i].exp_txd);
            end
            chk($sformatf("v%0d_cd_out", i), cd_out, vec[i].exp_cd);
            chk($sformatf("v%0d_level", i), fifo_level, 3'd0);
            chk($sformatf("v%0d_wr_delta", i), 16'(wr_count - wr0), STATS ? vec[i].wr_d : 0);
            chk($sformatf("v%0d_rd_delta", i), 16'(rd_count - rd0), STATS ? vec[i].rd_d : 0);
            chk($sformatf("v%0d_drop_delta", i), 16'(drop_count - dr0), 0);
        end

        // Overflow: six writes with the core stalled
        do_reset();
        obs.delete();
        ack_en = 1'b0;
        for (int i = 1; i <= 6; i++) cpu_write(2'd2, 8'(i), 6, 3);
        repeat (6) @(negedge clk);
        chk("ovf_level", fifo_level, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop_count", drop_count, STATS ? 16'd2 : 16'd0);
        chk("ovf_wr_count", wr_count, STATS ? 16'd4 : 16'd0);
        chk("ovf_req_held", vif.vdp_req, 1'b1);
        chk("ovf_dbo_held", vif.vdp_dbo, 8'h01);
        chk("ovf_adr_held", vif.vdp_adr, 2'd2);
        lat_cfg = 1;
        ack_en  = 1'b1;
        wait_idle("ovf_drain");
        for (int i = 1; i <= 4; i++) exp_q.push_back('{1'b1, 2'd2, 8'(i)});
        compare_obs("ovf");
        chk("ovf_sticky", overflow, 1'b1);

        // Write then immediate read: write handshake must finish first
        do_reset();
        init_rf();
        obs.delete();
        lat_cfg = 12;
        cpu_write(2'd0, 8'h11, 6, 1);
        cpu_read(2'd1, 10, 4);
        wait_idle("wr_rd");
        exp_q.push_back('{1'b1, 2'd0, 8'h11});
        exp_q.push_back('{1'b0, 2'd1, 8'h7E});
        compare_obs("wr_rd");
        chk("wr_rd_cd_out", cd_out, 8'h7E);
        chk("wr_rd_cd_oe_released", cd_oe, 1'b0);

        // Reset while a read request is outstanding
        do_reset();
        obs.delete();
        ack_en = 1'b0;
        @(posedge clk); #1 mode = 2'd3;
        @(posedge clk); #1 csr_n = 1'b0;
        k = 0;
        while (vif.vdp_req !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("rdreq_seen", vif.vdp_req, 1'b1);
        chk("rdreq_wrt", vif.vdp_wrt, 1'b0);
        chk("rdreq_adr", vif.vdp_adr, 2'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_req", vif.vdp_req, 1'b0);
        csr_n = 1'b1;
        ack_en = 1'b1;
        lat_cfg = 2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_req_rise = 0;
        obs.delete();
        repeat (30) @(posedge clk);
        chk("no_retry_req", n_req_rise, 0);
        chk("no_retry_txn", obs.size(), 0);
        cpu_write(2'd3, 8'h9C, 6, 3);
        wait_idle("post_rst");
        exp_q.push_back('{1'b1, 2'd3, 8'h9C});
        compare_obs("post_rst");

        // Randomized traffic against a CPU-order register model
        do_reset();
        init_rf();
        for (int i = 0; i < 4; i++) exp_rf[i] = core_rf[i];
        obs.delete();
        exp_q.delete();
        lat_cfg = 0;
        exp_wr = 0; exp_rd = 0;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            m  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (op < 2) begin
                exp_q.push_back('{1'b1, m, d});
                exp_rf[m] = d;
                exp_wr++;
                cpu_write(m, d, $urandom_range(4, 6), $urandom_range(2, 5));
                if ($urandom_range(0, 3) == 0) begin
                    wait_idle("rnd_w");
                    compare_obs("rnd_w");
                end
            end else begin
                exp_cd = exp_rf[m];
                exp_q.push_back('{1'b0, m, exp_cd});
                exp_rd++;
                cpu_read(m, $urandom_range(4, 8), $urandom_range(2, 5));
                wait_idle("rnd_r");
                compare_obs("rnd_r");
                chk("rnd_cd_out", cd_out, exp_cd);
            end
        end
        wait_idle("rnd_end");
        compare_obs("rnd_end");
        chk("rnd_overflow", overflow, 1'b0);
        chk("rnd_level", fifo_level, 3'd0);
        chk("rnd_wr_count", wr_count, STATS ? exp_wr : 0);
        chk("rnd_rd_count", rd_count, STATS ? exp_rd : 0);
        chk("rnd_drop_count", drop_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, width of the register-select (mode) bus.
REQ-002 SHALL have parameter DATA_W, default 8, width of the CPU data bus.
REQ-003 SHALL have parameter FILT_LEN, default 3, number of consecutive equal samples a strobe needs before the filtered level changes.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, posted-write FIFO depth; power of two, at least 2.
REQ-005 SHALL have port clk_w  input  1  pixel/VDP clock; all flops on rising edge.
REQ-006 SHALL have port reset_n_w  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports csw_n, csr_n  input  1 each  raw CPU write/read strobes, active low, asynchronous to clk_w.
REQ-008 SHALL have port mode  input  ADDR_W  raw CPU register select.
REQ-009 SHALL have port cd_in  input  DATA_W  raw CPU write data.
REQ-010 SHALL have ports cd_out  output  DATA_W  last read data, and cd_oe  output  1  data-bus drive enable.
REQ-011 SHALL have ports vdp_req, vdp_wrt  output  1 each; vdp_adr  output  ADDR_W; vdp_dbo  output  DATA_W  VDP core request bus.
REQ-012 SHALL have ports vdp_ack  input  1  and vdp_dbi  input  DATA_W  VDP core acknowledge and read data.
REQ-013 SHALL have ports fifo_level  output  $clog2(FIFO_DEPTH+1), overflow  output  1  sticky, and wr_count, rd_count, drop_count  output  16 each.

Function
REQ-014 SHALL pass csw_n, csr_n, mode and cd_in through a 2-flop synchroniser each.
REQ-015 SHALL change each filtered strobe level only after FILT_LEN consecutive cycles of equal synchronised value.
REQ-016 SHALL detect a write strobe on the cycle filtered csw_n falls while filtered csr_n is high, capturing synchronised mode and cd_in on that cycle.
REQ-017 SHALL detect a read strobe on the cycle filtered csr_n falls while filtered csw_n is high, latching synchronised mode into rd_adr and setting rd_pending.
REQ-018 SHALL ignore both edges when both filtered strobes fall in the same cycle.
REQ-019 SHALL push each write strobe as {mode, data} into the FIFO; when full, SHALL drop the write and set overflow.
REQ-020 SHALL implement states IDLE, WR_REQ, RD_REQ and RD_HOLD.
REQ-021 IDLE: SHALL pop the FIFO and go to WR_REQ if FIFO non-empty; else go to RD_REQ if rd_pending.
REQ-022 Reads SHALL wait until the FIFO is empty, preserving CPU order.
REQ-023 WR_REQ: SHALL hold vdp_req=1, vdp_wrt=1 and the popped adr/data stable until vdp_ack=1, then return to IDLE with vdp_req=0 on the next cycle.
REQ-024 RD_REQ: SHALL hold vdp_req=1, vdp_wrt=0, vdp_adr=rd_adr until vdp_ack=1; SHALL load vdp_dbi into cd_out 1 cycle after ack, clear rd_pending and go to RD_HOLD.
REQ-025 RD_HOLD: SHALL return to IDLE when filtered csr_n is high; write strobes arriving meanwhile SHALL still be queued.
REQ-026 cd_oe SHALL equal ~csr_n, the raw pin, combinationally; this is the only combinational path.
REQ-027 A push and a pop in the same cycle SHALL leave fifo_level unchanged; push when full plus pop in the same cycle SHALL be accepted.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 Asserting reset_n_w SHALL asynchronously clear: state to IDLE, vdp_req/vdp_wrt to 0, vdp_adr/vdp_dbo/cd_out to 0, FIFO empty, fifo_level 0, overflow 0, rd_pending 0, all counters 0.
REQ-030 Reset SHALL set filters and synchronisers to 1, so no strobe is detected on release.
REQ-031 Reset mid-handshake SHALL abandon the transaction with no retry.

Configuration
REQ-032 With VDP_CPU_PORT_STATS_EN defined, wr_count, rd_count and drop_count SHALL count accepted writes, completed reads and dropped writes, saturating at 16'hFFFF.
REQ-033 Without VDP_CPU_PORT_STATS_EN, the three counters SHALL be constant 0 with no flops inferred; ports SHALL remain present.

Verification
REQ-034 Single write, mode=2'b01, cd=8'hA5, ack after 2 cycles -> exactly one vdp_req pulse with vdp_wrt=1, vdp_adr=1, vdp_dbo=A5; fifo_level returns to 0.
REQ-035 Glitch: csw_n low for FILT_LEN-1 cycles -> no FIFO push, vdp_req stays 0.
REQ-036 Six writes 01..06 with vdp_ack held 0 -> fifo_level=4, overflow=1, drop_count=2; after releasing ack, data 01..04 issued in order.
REQ-037 Write 8'h11 then immediate read, vdp_dbi=8'h7E -> write handshake completes before read vdp_req; cd_out=7E; cd_oe low while csr_n high.
REQ-038 csw_n and csr_n fall together -> no request and counters unchanged; reset asserted during RD_REQ -> vdp_req=0 asynchronously, state IDLE.
